pattern_round_ctrl: RTL

Avalon-MM slave that sequences one round of the key-pattern game on the DE10-Nano.
- HPS loads a pattern and starts a round; the block shows the pattern on the LEDs for a fixed time.
- It then collects debounced push-button entries, compares them with the pattern, and keeps score.
- It raises an interrupt at round end. It sits beside the existing PIO slave in soc_system and drives the same pattern_keys/user_keys/led outputs.

---
 rtl/pattern_round_pkg.sv | 36 +++
 rtl/key_debounce.sv | 50 +++++
 rtl/pattern_round_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pattern_round_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_round_pkg
// Description : Shared state encodings, register map and LED result codes
//               for the key-pattern round controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_round_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_SHOW  = 3'd1;
    localparam state_t c_ST_INPUT = 3'd2;
    localparam state_t c_ST_CHECK = 3'd3;
    localparam state_t c_ST_DONE  = 3'd4;

    localparam logic [1:0] c_ADDR_CTRL    = 2'd0;
    localparam logic [1:0] c_ADDR_PATTERN = 2'd1;
    localparam logic [1:0] c_ADDR_STATUS  = 2'd2;
    localparam logic [1:0] c_ADDR_SCORE   = 2'd3;

    localparam int c_CTRL_START   = 0;
    localparam int c_CTRL_ABORT   = 1;
    localparam int c_CTRL_IRQ_CLR = 2;

    localparam logic [7:0] c_LED_PASS    = 8'hFF;
    localparam logic [7:0] c_LED_FAIL    = 8'hAA;
    localparam logic [7:0] c_LED_TIMEOUT = 8'h0F;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : 2-FF synchronizer plus stability counter for one active-low
//               push button; emits a 1-cycle pulse on a debounced press.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int              c_CW   = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      r_sync;
    logic            r_level;
    logic [c_CW-1:0] r_cnt;
    logic            r_press;

    // Idle level is 1 (released), so leaving reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_LAST) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_press <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/pattern_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pattern_round_ctrl
// Description : Avalon-MM slave sequencing one round of the key-pattern game:
//               show pattern, collect key entries, score, raise irq.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_round_ctrl
    import pattern_round_pkg::*;
#(
    parameter int SHOW_CYCLES     = 50000000,
    parameter int TIMEOUT_CYCLES  = 250000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [1:0]  key,
    input  logic [3:0]  switch,
    output logic [7:0]  pattern_keys,
    output logic [7:0]  user_keys,
    output logic [7:0]  led,
    output logic        irq
);

    localparam logic [31:0] c_SHOW_LAST    = 32'(SHOW_CYCLES - 1);
    localparam logic [31:0] c_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_pattern;
    logic [3:0]  r_len;
    logic [7:0]  r_user;
    logic [3:0]  r_count;
    logic        r_pass;
    logic        r_fail;
    logic        r_timeout;
    logic        r_irq;
    logic [15:0] r_passed;
    logic [15:0] r_played;
    logic [31:0] r_timer;
    logic [31:0] r_readdata;

    logic [1:0]  w_press;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .clk     (clk),
                .rst     (reset),
                .i_key_n (key[g]),
                .o_press (w_press[g])
            );
        end
    endgenerate

    logic w_ctrl_wr, w_start, w_abort, w_irq_clr, w_pat_wr, w_score_wr;
    logic w_round_start, w_entry, w_entry_bit, w_show_done, w_timeout_hit, w_match;
    logic [7:0] w_mask;
    logic w_unused;

    assign w_ctrl_wr     = write && (address == c_ADDR_CTRL);
    assign w_start       = w_ctrl_wr && writedata[c_CTRL_START];
    assign w_abort       = w_ctrl_wr && writedata[c_CTRL_ABORT];
    assign w_irq_clr     = w_ctrl_wr && writedata[c_CTRL_IRQ_CLR];
    assign w_pat_wr      = write && (address == c_ADDR_PATTERN) &&
                           ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_score_wr    = write && (address == c_ADDR_SCORE);
    assign w_round_start = w_start && !w_abort &&
                           ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));

    // key[0] has priority when both presses land in the same cycle.
    assign w_entry       = (r_state == c_ST_INPUT) && (w_press != 2'b00) && (r_count < r_len);
    assign w_entry_bit   = w_press[1] && !w_press[0];
    assign w_show_done   = (r_timer == c_SHOW_LAST);
    assign w_timeout_hit = (r_timer == c_TIMEOUT_LAST);
    assign w_mask        = 8'hFF >> (4'd8 - r_len);
    assign w_match       = ((r_user ^ r_pattern) & w_mask) == 8'h00;
    assign w_unused      = &{1'b0, switch[3:1], writedata[31:12]};

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:  if (w_start) w_state_nxt = c_ST_SHOW;
                c_ST_SHOW:  if (w_show_done) w_state_nxt = c_ST_INPUT;
                c_ST_INPUT: begin
                    if (r_count == r_len)                w_state_nxt = c_ST_CHECK;
                    else if (!w_entry && w_timeout_hit)  w_state_nxt = c_ST_DONE;
                end
                c_ST_CHECK: w_state_nxt = c_ST_DONE;
                c_ST_DONE:  if (w_start) w_state_nxt = c_ST_SHOW;
                default:    w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pattern_keys = 8'h00;
        led          = 8'h00;
        case (r_state)
            c_ST_SHOW: begin
                pattern_keys = r_pattern;
                led          = r_pattern;
            end
            c_ST_INPUT: led = switch[0] ? r_user : 8'h00;
            c_ST_DONE: begin
                if (r_pass)         led = c_LED_PASS;
                else if (r_fail)    led = c_LED_FAIL;
                else if (r_timeout) led = c_LED_TIMEOUT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern <= '0;
            r_len     <= '0;
            r_user    <= '0;
            r_count   <= '0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
            r_irq     <= 1'b0;
            r_passed  <= '0;
            r_played  <= '0;
            r_timer   <= '0;
        end else begin
            if (w_pat_wr) begin
                r_pattern <= writedata[7:0];
                r_len     <= ((writedata[11:8] == 4'd0) || (writedata[11:8] > 4'd8)) ?
                             4'd8 : writedata[11:8];
            end
            if (w_abort || w_round_start) begin
                r_user    <= '0;
                r_count   <= '0;
                r_pass    <= 1'b0;
                r_fail    <= 1'b0;
                r_timeout <= 1'b0;
                r_irq     <= 1'b0;
                r_timer   <= '0;
                if (w_round_start) r_played <= sat_inc(r_played);
            end else begin
                if (w_irq_clr) r_irq <= 1'b0;
                case (r_state)
                    c_ST_SHOW: r_timer <= w_show_done ? 32'd0 : r_timer + 32'd1;
                    c_ST_INPUT: begin
                        // Every accepted press restarts the inactivity timer.
                        if (w_entry) begin
                            r_user[r_count[2:0]] <= w_entry_bit;
                            r_count              <= r_count + 4'd1;
                            r_timer              <= '0;
                        end else if ((r_count != r_len) && w_timeout_hit) begin
                            r_timeout <= 1'b1;
                            r_irq     <= 1'b1;
                            r_timer   <= '0;
                        end else begin
                            r_timer <= r_timer + 32'd1;
                        end
                    end
                    c_ST_CHECK: begin
                        if (w_match) begin
                            r_pass   <= 1'b1;
                            r_passed <= sat_inc(r_passed);
                        end else begin
                            r_fail <= 1'b1;
                        end
                        r_irq <= 1'b1;
                    end
                    default: r_timer <= '0;
                endcase
            end
            if (w_score_wr) begin
                r_passed <= '0;
                r_played <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (read) begin
            case (address)
                c_ADDR_STATUS: r_readdata <= {20'd0, r_count, 2'b00, r_timeout, r_fail, r_pass, r_state};
                c_ADDR_SCORE:  r_readdata <= {r_played, r_passed};
                default:       r_readdata <= '0;
            endcase
        end else begin
            r_readdata <= '0;
        end
    end

    assign user_keys = r_user;
    assign irq       = r_irq;
    assign readdata  = r_readdata;

endmodule
`default_nettype wire
